// File: rtl/vga_timing_if.sv
// VGA timing bus: counts, syncs, blanks and frame marker driven by the timing
// generator and consumed by every downstream pixel stage.
interface vga_timing_if;
  logic [10:0] hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic [10:0] vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic        frame_start;

  modport master (
    output hcount_out, hsync_out, hblnk_out,
    output vcount_out, vsync_out, vblnk_out,
    output frame_start
  );

  modport slave (
    input hcount_out, hsync_out, hblnk_out,
    input vcount_out, vsync_out, vblnk_out,
    input frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Source of the VGA timing bus: free-running h/v counters with sync, blank
// and frame-start flags decoded from the next counts so all outputs align.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic         pclk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All decode points as 11-bit constants so every compare is unsigned 11-bit.
  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLNK_FROM = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_FROM = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_TO   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLNK_FROM = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_FROM = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_TO   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
    end
    if (H_TOTAL == 0 || V_TOTAL == 0) begin : g_zero_totals
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be non-zero");
    end
  endgenerate

  // Registered state.
  logic [10:0] hcount_q;
  logic [10:0] vcount_q;
  logic        hsync_q;
  logic        hblnk_q;
  logic        vsync_q;
  logic        vblnk_q;
  logic        frame_start_q;

  // Next state.
  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;
  logic        hsync_nxt;
  logic        hblnk_nxt;
  logic        vsync_nxt;
  logic        vblnk_nxt;
  logic        frame_start_nxt;

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (hcount_q == H_LAST);
  assign v_wrap = (vcount_q == V_LAST);

  // The vertical counter only moves on the edge where the line wraps.
  always_comb begin
    hcount_nxt = hcount_q + 11'd1;
    vcount_nxt = vcount_q;
    if (h_wrap) begin
      hcount_nxt = '0;
      vcount_nxt = v_wrap ? 11'd0 : vcount_q + 11'd1;
    end
  end

  // Flags come from the next counts so they land in the same register stage.
  always_comb begin
    hblnk_nxt       = (hcount_nxt >= H_BLNK_FROM);
    vblnk_nxt       = (vcount_nxt >= V_BLNK_FROM);
    hsync_nxt       = SYNC_OFF;
    vsync_nxt       = SYNC_OFF;
    frame_start_nxt = h_wrap && v_wrap;
    if ((hcount_nxt >= H_SYNC_FROM) && (hcount_nxt <= H_SYNC_TO)) begin
      hsync_nxt = SYNC_ON;
    end
    if ((vcount_nxt >= V_SYNC_FROM) && (vcount_nxt <= V_SYNC_TO)) begin
      vsync_nxt = SYNC_ON;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset
  // clears every output so no partial sync pulse survives a mid-frame reset.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= SYNC_OFF;
      hblnk_q       <= 1'b0;
      vsync_q       <= SYNC_OFF;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_nxt;
      vcount_q      <= vcount_nxt;
      hsync_q       <= hsync_nxt;
      hblnk_q       <= hblnk_nxt;
      vsync_q       <= vsync_nxt;
      vblnk_q       <= vblnk_nxt;
      frame_start_q <= frame_start_nxt;
    end
  end

  assign vga.hcount_out  = hcount_q;
  assign vga.vcount_out  = vcount_q;
  assign vga.hsync_out   = hsync_q;
  assign vga.hblnk_out   = hblnk_q;
  assign vga.vsync_out   = vsync_q;
  assign vga.vblnk_out   = vblnk_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x600 timing for line behaviour, plus a
// shrunken active-low instance (25x16 totals) for whole-frame behaviour.
module tb_vga_timing_gen;

  logic pclk;
  logic rst;

  vga_timing_if d_if ();
  vga_timing_if s_if ();

  vga_timing_gen u_dflt (
    .pclk (pclk),
    .rst  (rst),
    .vga  (d_if)
  );

  // Small: hblnk 16..24, hsync 18..21, vblnk 10..15, vsync 11..12, frame 400.
  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (10), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b0)
  ) u_small (
    .pclk (pclk),
    .rst  (rst),
    .vga  (s_if)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference positions, advanced independently of the DUTs.
  int  mh, mv, sh, sv;
  logic m_fs, s_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_all();
    check("d_hcount", 32'(d_if.hcount_out), 32'(mh));
    check("d_vcount", 32'(d_if.vcount_out), 32'(mv));
    check("d_hblnk",  32'(d_if.hblnk_out),  32'(mh >= 800));
    check("d_hsync",  32'(d_if.hsync_out),  32'(mh >= 840 && mh <= 967));
    check("d_vblnk",  32'(d_if.vblnk_out),  32'(mv >= 600));
    check("d_vsync",  32'(d_if.vsync_out),  32'(mv >= 601 && mv <= 604));
    check("d_fs",     32'(d_if.frame_start), 32'(m_fs));
    check("s_hcount", 32'(s_if.hcount_out), 32'(sh));
    check("s_vcount", 32'(s_if.vcount_out), 32'(sv));
    check("s_hblnk",  32'(s_if.hblnk_out),  32'(sh >= 16));
    check("s_hsync",  32'(s_if.hsync_out),  32'(!(sh >= 18 && sh <= 21)));
    check("s_vblnk",  32'(s_if.vblnk_out),  32'(sv >= 10));
    check("s_vsync",  32'(s_if.vsync_out),  32'(!(sv >= 11 && sv <= 12)));
    check("s_fs",     32'(s_if.frame_start), 32'(s_fs));
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; sh = 0; sv = 0; m_fs = 1'b0; s_fs = 1'b0;
  endtask

  // One clock: advance the reference on the edge, compare on the falling edge.
  task automatic step();
    @(posedge pclk);
    if (rst) begin
      model_reset();
    end else begin
      m_fs = (mh == 1055 && mv == 627);
      if (mh == 1055) begin
        mh = 0;
        mv = (mv == 627) ? 0 : mv + 1;
      end else mh = mh + 1;
      s_fs = (sh == 24 && sv == 15);
      if (sh == 24) begin
        sh = 0;
        sv = (sv == 15) ? 0 : sv + 1;
      end else sh = sh + 1;
    end
    @(negedge pclk);
    check_all();
  endtask

  initial begin
    int hs_first, hs_cnt, hb_rise, hb_fall, lw_h, lw_v;
    logic prev_hs, prev_hb;
    int prev_h;
    int n_fs, gap, vs_cnt, vb_cnt, k;

    rst = 1'b1;
    model_reset();
    repeat (5) @(negedge pclk);
    check_all();

    rst = 1'b0;
    step();
    check("d_first_edge_h", 32'(d_if.hcount_out), 32'd1);
    check("s_first_edge_h", 32'(s_if.hcount_out), 32'd1);

    // Default line timing over two full lines.
    hs_first = -1; hs_cnt = 0; hb_rise = -1; hb_fall = -1; lw_h = -1; lw_v = -1;
    prev_hs = d_if.hsync_out; prev_hb = d_if.hblnk_out; prev_h = d_if.hcount_out;
    for (int i = 0; i < 2 * 1056 + 20; i++) begin
      step();
      if (d_if.hsync_out && !prev_hs && hs_first < 0) hs_first = d_if.hcount_out;
      if (d_if.hsync_out && d_if.vcount_out == 0) hs_cnt++;
      if (d_if.hblnk_out && !prev_hb && hb_rise < 0) hb_rise = d_if.hcount_out;
      if (!d_if.hblnk_out && prev_hb && hb_fall < 0) hb_fall = d_if.hcount_out;
      if (prev_h == 1055 && lw_h < 0) begin
        lw_h = d_if.hcount_out;
        lw_v = d_if.vcount_out;
      end
      prev_hs = d_if.hsync_out; prev_hb = d_if.hblnk_out; prev_h = d_if.hcount_out;
    end
    check("d_hsync_first", 32'(hs_first), 32'd840);
    check("d_hsync_len",   32'(hs_cnt),   32'd128);
    check("d_hblnk_rise",  32'(hb_rise),  32'd800);
    check("d_hblnk_fall",  32'(hb_fall),  32'd0);
    check("d_wrap_h",      32'(lw_h),     32'd0);
    check("d_wrap_v",      32'(lw_v),     32'd1);

    // Small instance: one full frame between two frame_start pulses.
    n_fs = 0; gap = 0; vs_cnt = 0; vb_cnt = 0; k = 0;
    while (n_fs < 2 && k < 1000) begin
      step();
      k++;
      if (n_fs >= 1) begin
        gap++;
        if (!s_if.vsync_out) vs_cnt++;
        if (s_if.vblnk_out) vb_cnt++;
      end
      if (s_if.frame_start) n_fs++;
    end
    check("s_fs_pulses", 32'(n_fs),   32'd2);
    check("s_fs_period", 32'(gap),    32'd400);
    check("s_vsync_len", 32'(vs_cnt), 32'd50);
    check("s_vblnk_len", 32'(vb_cnt), 32'd150);

    // Park the small instance mid-vsync, then reset between clock edges.
    k = 0;
    while (!(sh == 22 && sv == 11) && k < 1000) begin
      step();
      k++;
    end
    check("s_seek_mid_vsync", 32'(sh == 22 && sv == 11), 32'd1);
    check("s_vsync_before_rst", 32'(s_if.vsync_out), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("s_async_h",  32'(s_if.hcount_out),  32'd0);
    check("s_async_v",  32'(s_if.vcount_out),  32'd0);
    check("s_async_vs", 32'(s_if.vsync_out),   32'd1);
    check("s_async_hs", 32'(s_if.hsync_out),   32'd1);
    check("s_async_vb", 32'(s_if.vblnk_out),   32'd0);
    check("s_async_hb", 32'(s_if.hblnk_out),   32'd0);
    check("d_async_h",  32'(d_if.hcount_out),  32'd0);
    check("d_async_v",  32'(d_if.vcount_out),  32'd0);
    model_reset();
    repeat (3) step();

    rst = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!s_if.frame_start && k < 1000);
    check("s_fs_after_rst", 32'(k), 32'd400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
